// File: rtl/bib_yanitlayici_pkg.sv
// bib_yanitlayici_pkg: shared state encoding, default window parameters and range helper
package bib_yanitlayici_pkg;
  typedef enum logic [1:0] {BOSTA, BEKLE, YANIT} durum_t;
  localparam int VARSAYILAN_DERINLIK = 1024;
  localparam logic [31:0] VARSAYILAN_TABAN = 32'h4000_0000;
  localparam int VARSAYILAN_BEKLE = 2;
  function automatic logic pencerede(input logic [31:0] ofs, input int derinlik);
    return ofs < 32'(derinlik) * 32'd4;
  endfunction
endpackage

// File: rtl/bib_yanitlayici_if.sv
// bib_yanitlayici_if: BIB load/store bus signals between initiator and responder
interface bib_yanitlayici_if;
  logic bib_sec_i;
  logic [31:0] bib_adr_i;
  logic [31:0] bib_veri_i;
  logic [3:0] bib_veri_maske_i;
  logic [31:0] bib_veri_o;
  logic bib_durdur_o;
  logic bib_hata_o;
  modport master(output bib_sec_i, bib_adr_i, bib_veri_i, bib_veri_maske_i, input bib_veri_o, bib_durdur_o, bib_hata_o);
  modport slave(input bib_sec_i, bib_adr_i, bib_veri_i, bib_veri_maske_i, output bib_veri_o, bib_durdur_o, bib_hata_o);
endinterface

// File: rtl/bib_yanitlayici_bayt_maskeli_sram.sv
// bib_yanitlayici_bayt_maskeli_sram: 32-bit word RAM, synchronous read, per-byte write enables
module bib_yanitlayici_bayt_maskeli_sram #(
  parameter int DERINLIK = 1024,
  parameter int AW = $clog2(DERINLIK)
)(
  input  logic          clk_i,
  input  logic          oku,
  input  logic [AW-1:0] oku_adr,
  output logic [31:0]   oku_veri,
  input  logic [3:0]    yaz,
  input  logic [AW-1:0] yaz_adr,
  input  logic [31:0]   yaz_veri
);
  logic [31:0] mem [DERINLIK];
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++)
      if (yaz[b]) mem[yaz_adr][8*b +: 8] <= yaz_veri[8*b +: 8];
    if (oku) oku_veri <= mem[oku_adr];
  end
endmodule

// File: rtl/bib_yanitlayici.sv
// bib_yanitlayici: BIB bus responder with wait states, byte-masked RAM and window check
module bib_yanitlayici import bib_yanitlayici_pkg::*; #(
  parameter int          DERINLIK     = VARSAYILAN_DERINLIK,
  parameter logic [31:0] TABAN_ADRES  = VARSAYILAN_TABAN,
  parameter int          BEKLE_SAYISI = VARSAYILAN_BEKLE
)(
  input logic clk_i,
  input logic rst_i,
  bib_yanitlayici_if.slave bib
);
  localparam int AW = $clog2(DERINLIK);
  durum_t durum, sonraki;
  logic [3:0] sayac, sayac_d, maske_r;
  logic [AW-1:0] idx_r;
  logic [31:0] veri_r, oku_veri, ofs;
  logic hata_r, yakala;
  assign ofs = bib.bib_adr_i - TABAN_ADRES;
  always_comb begin
    sonraki = durum;
    sayac_d = sayac;
    yakala = 1'b0;
    case (durum)
      BOSTA: if (bib.bib_sec_i) begin
        yakala = 1'b1;
        sayac_d = 4'(BEKLE_SAYISI);
        sonraki = BEKLE_SAYISI > 0 ? BEKLE : YANIT;
      end
      BEKLE: if (!bib.bib_sec_i) sonraki = BOSTA;
      else begin
        sayac_d = sayac - 4'd1;
        sonraki = sayac == 4'd1 ? YANIT : BEKLE;
      end
      default: sonraki = BOSTA;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      durum <= BOSTA;
      sayac <= '0;
      hata_r <= 1'b0;
    end else begin
      durum <= sonraki;
      sayac <= sayac_d;
      if (yakala) begin
        idx_r <= ofs[AW+1:2];
        veri_r <= bib.bib_veri_i;
        maske_r <= bib.bib_veri_maske_i;
        hata_r <= !pencerede(ofs, DERINLIK);
      end
    end
  end
  // read happens at capture; the write lands only at the response edge so aborts and resets never write
  bib_yanitlayici_bayt_maskeli_sram #(.DERINLIK(DERINLIK)) u_sram (
    .clk_i   (clk_i),
    .oku     (yakala),
    .oku_adr (ofs[AW+1:2]),
    .oku_veri(oku_veri),
    .yaz     ((rst_i && durum == YANIT && !hata_r) ? maske_r : 4'b0),
    .yaz_adr (idx_r),
    .yaz_veri(veri_r)
  );
  assign bib.bib_durdur_o = bib.bib_sec_i && durum != YANIT;
  assign bib.bib_veri_o = (durum == YANIT && !hata_r) ? oku_veri : '0;
  assign bib.bib_hata_o = durum == YANIT && hata_r;
endmodule

// File: tb/tb_bib_yanitlayici.sv
// tb_bib_yanitlayici: directed and randomized checks of the BIB responder against a word-array model
module tb_bib_yanitlayici;
  import bib_yanitlayici_pkg::*;
  localparam logic [31:0] TABAN = 32'h4000_0000;
  localparam int DER = 1024;
  logic clk = 1'b0, rst = 1'b0;
  int n_kar = 0, n_hata = 0;
  logic [31:0] mm [DER];
  bit bil [DER];
  always #5 clk = ~clk;
  bib_yanitlayici_if b2();
  bib_yanitlayici_if b0();
  bib_yanitlayici #(.DERINLIK(DER), .TABAN_ADRES(TABAN), .BEKLE_SAYISI(2)) d2 (.clk_i(clk), .rst_i(rst), .bib(b2.slave));
  bib_yanitlayici #(.DERINLIK(DER), .TABAN_ADRES(TABAN), .BEKLE_SAYISI(0)) d0 (.clk_i(clk), .rst_i(rst), .bib(b0.slave));

  task automatic kontrol(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_kar++;
    if (got !== exp) begin
      n_hata++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic islem(input logic [31:0] a, input logic [31:0] v, input logic [3:0] m,
                       output logic [31:0] rd, output logic h, output int cnt);
    @(negedge clk);
    b2.bib_sec_i = 1'b1;
    b2.bib_adr_i = a;
    b2.bib_veri_i = v;
    b2.bib_veri_maske_i = m;
    #1;
    cnt = 0;
    while (b2.bib_durdur_o && cnt < 20) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    rd = b2.bib_veri_o;
    h = b2.bib_hata_o;
    @(posedge clk);
    #1 b2.bib_sec_i = 1'b0;
  endtask

  task automatic yap(input string tag, input logic [31:0] a, input logic [31:0] v, input logic [3:0] m,
                     output logic [31:0] rd, output logic h);
    int cnt, i;
    logic eh;
    eh = !(a >= TABAN && a < TABAN + 32'(DER * 4));
    i = eh ? 0 : int'((a - TABAN) / 4);
    islem(a, v, m, rd, h, cnt);
    kontrol({tag, "_sure"}, 32'(cnt), 32'd3);
    kontrol({tag, "_hata"}, {31'b0, h}, {31'b0, eh});
    if (eh) kontrol({tag, "_veri"}, rd, 32'h0);
    else if (bil[i]) kontrol({tag, "_veri"}, rd, mm[i]);
    if (!eh) begin
      for (int b = 0; b < 4; b++) if (m[b]) mm[i][8*b +: 8] = v[8*b +: 8];
      if (m == 4'hF) bil[i] = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a, v, ta [4], tv [4];
    logic [3:0] m, tm [4];
    logic h;
    int c, r;
    b2.bib_sec_i = 1'b0; b2.bib_adr_i = '0; b2.bib_veri_i = '0; b2.bib_veri_maske_i = '0;
    b0.bib_sec_i = 1'b0; b0.bib_adr_i = '0; b0.bib_veri_i = '0; b0.bib_veri_maske_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    kontrol("rst_veri", b2.bib_veri_o, 32'h0);
    kontrol("rst_hata", {31'b0, b2.bib_hata_o}, 32'h0);
    kontrol("rst_durdur", {31'b0, b2.bib_durdur_o}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    // write then read back
    yap("t1_yaz", 32'h4000_0010, 32'hCAFE_BABE, 4'hF, rd, h);
    yap("t1_oku", 32'h4000_0010, 32'h0, 4'h0, rd, h);
    kontrol("t1_deger", rd, 32'hCAFE_BABE);
    // byte and halfword masks
    yap("t2_on", 32'h4000_0020, 32'h1122_3344, 4'hF, rd, h);
    yap("t2_bayt", 32'h4000_0020, 32'h00AA_0000, 4'b0100, rd, h);
    yap("t2_yarim", 32'h4000_0020, 32'h0000_BEEF, 4'b0011, rd, h);
    yap("t2_oku", 32'h4000_0020, 32'h0, 4'h0, rd, h);
    kontrol("t2_deger", rd, 32'h11AA_BEEF);
    // out of window, including the address that aliases word 0
    yap("t3_on", TABAN, 32'h0123_4567, 4'hF, rd, h);
    yap("t3_yaz", TABAN + 32'(DER * 4), 32'hDEAD_BEEF, 4'hF, rd, h);
    kontrol("t3_yaz_hata", {31'b0, h}, 32'h1);
    yap("t3_w0", TABAN, 32'h0, 4'h0, rd, h);
    kontrol("t3_w0_deger", rd, 32'h0123_4567);
    yap("t3_alt", 32'h3FFF_FFFC, 32'h0, 4'h0, rd, h);
    kontrol("t3_alt_veri", rd, 32'h0);
    kontrol("t3_alt_hata", {31'b0, h}, 32'h1);
    // abort in the second wait cycle
    yap("t4_on", 32'h4000_0030, 32'h0000_0055, 4'hF, rd, h);
    @(negedge clk);
    b2.bib_sec_i = 1'b1; b2.bib_adr_i = 32'h4000_0030; b2.bib_veri_i = 32'hFFFF_FFFF; b2.bib_veri_maske_i = 4'hF;
    @(posedge clk);
    @(negedge clk);
    kontrol("t4_bekle_durdur", {31'b0, b2.bib_durdur_o}, 32'h1);
    @(posedge clk);
    #1 b2.bib_sec_i = 1'b0;
    @(negedge clk);
    kontrol("t4_durdur", {31'b0, b2.bib_durdur_o}, 32'h0);
    @(posedge clk);
    #1 kontrol("t4_durum", 32'(d2.durum), 32'(BOSTA));
    yap("t4_oku", 32'h4000_0030, 32'h0, 4'h0, rd, h);
    kontrol("t4_deger", rd, 32'h0000_0055);
    // reset during the wait of a write; held sel restarts as a read
    yap("t5_on", 32'h4000_0040, 32'h0000_0077, 4'hF, rd, h);
    @(negedge clk);
    b2.bib_sec_i = 1'b1; b2.bib_adr_i = 32'h4000_0040; b2.bib_veri_i = 32'hDEAD_BEEF; b2.bib_veri_maske_i = 4'hF;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    kontrol("t5_rst_veri", b2.bib_veri_o, 32'h0);
    kontrol("t5_rst_hata", {31'b0, b2.bib_hata_o}, 32'h0);
    kontrol("t5_rst_durum", 32'(d2.durum), 32'(BOSTA));
    @(posedge clk);
    #1 rst = 1'b1;
    b2.bib_veri_maske_i = 4'h0;
    @(negedge clk);
    #1;
    c = 0;
    while (b2.bib_durdur_o && c < 20) begin
      c++;
      @(negedge clk);
      #1;
    end
    kontrol("t5_sure", 32'(c), 32'd3);
    kontrol("t5_deger", b2.bib_veri_o, 32'h0000_0077);
    kontrol("t5_hata", {31'b0, b2.bib_hata_o}, 32'h0);
    @(posedge clk);
    #1 b2.bib_sec_i = 1'b0;
    // randomized traffic against the word-array model
    repeat (60) begin
      r = $urandom_range(0, 9);
      if (r < 8) a = TABAN + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      else if (r == 8) a = TABAN + 32'(DER * 4) + 32'(4 * $urandom_range(0, 100));
      else a = TABAN - 32'(4 * $urandom_range(1, 100));
      v = $urandom;
      m = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) m = 4'h0;
      yap("rnd", a, v, m, rd, h);
    end
    // zero wait states, back-to-back with sel held high
    tv[0] = $urandom; tv[1] = $urandom;
    ta[0] = 32'h4000_0100; tv[0] = tv[0]; tm[0] = 4'hF;
    ta[1] = 32'h4000_0104; tm[1] = 4'hF;
    ta[2] = 32'h4000_0104; tv[2] = 32'h0; tm[2] = 4'h0;
    ta[3] = 32'h4000_0100; tv[3] = 32'h0; tm[3] = 4'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      b0.bib_sec_i = 1'b1;
      b0.bib_adr_i = ta[k/2];
      b0.bib_veri_i = tv[k/2];
      b0.bib_veri_maske_i = tm[k/2];
      #1;
      kontrol($sformatf("t6_durdur%0d", k), {31'b0, b0.bib_durdur_o}, (k % 2 == 0) ? 32'h1 : 32'h0);
      if (k % 2 == 1) begin
        kontrol($sformatf("t6_hata%0d", k), {31'b0, b0.bib_hata_o}, 32'h0);
        if (k == 5) kontrol("t6_oku_w2", b0.bib_veri_o, tv[1]);
        if (k == 7) kontrol("t6_oku_w1", b0.bib_veri_o, tv[0]);
      end
    end
    @(posedge clk);
    #1 b0.bib_sec_i = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_kar, n_hata);
    $finish;
  end
endmodule
